fifo_pkt_writer: RTL and testbench

//  Write-side producer for async_fifo, clk_w domain. Accepts a valid/ready word stream with s_last.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_pkt_writer_if.sv | 23 ++
 rtl/fifo_wr_stage.sv | 39 +++
 rtl/fifo_pkt_writer.sv | 116 +++++++++++
 tb/tb_fifo_pkt_writer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async_fifo write/read side logic.
package fifo_pkg;

    typedef enum logic {
        S_DATA = 1'b0,
        S_TRL  = 1'b1
    } wr_state_e;

    localparam int SEQ_W_DEF = 2;

    // Trailer layout: sequence number in the top bits, length below it.
    function automatic logic [31:0] trl_word(
        input logic [31:0] seq,
        input logic [31:0] len,
        input int          dw,
        input int          sw
    );
        logic [31:0] mask;
        mask = (32'd1 << (dw - sw)) - 32'd1;
        return (seq << (dw - sw)) | (len & mask);
    endfunction

endpackage

// File: rtl/fifo_pkt_writer_if.sv
// Upstream word stream plus async_fifo write-port bundle.
interface fifo_pkt_writer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  full;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pkt_err;

    modport slave (
        input  s_valid, s_data, s_last, full,
        output s_ready, wr_en, data_in, pkt_err
    );

    modport master (
        output s_valid, s_data, s_last, full,
        input  s_ready, wr_en, data_in, pkt_err
    );
endinterface

// File: rtl/fifo_wr_stage.sv
// One-entry output register: load, pop or hold, with valid flag.
module fifo_wr_stage #(
    parameter int W = 8
) (
    input  logic         clk_w,
    input  logic         rst,
    input  logic         load_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);
    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load_i) begin
            vld_d = 1'b1;
            dat_d = din_i;
        end else if (pop_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_w or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;
endmodule

// File: rtl/fifo_pkt_writer.sv
// Packet writer into async_fifo: payload words then a {seq,len} trailer.
// Define FIFO_WR_STATS_EN to add the pkt_cnt trailer counter port.
module fifo_pkt_writer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SEQ_W       = SEQ_W_DEF,
    parameter int MAX_PKT_LEN = 63
) (
    input  logic               clk_w,
    input  logic               rst,
    fifo_pkt_writer_if.slave   bus
`ifdef FIFO_WR_STATS_EN
    ,
    output logic [15:0]        pkt_cnt
`endif
);
    localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);

    wr_state_e             state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic                  err_q, err_d;
    logic                  out_vld, can_load, load, at_max;
    logic [DATA_WIDTH-1:0] out_dat, ld_dat, trl_w;

    // Stage can take a word when empty or when it drains this cycle.
    assign can_load    = !out_vld || !bus.full;
    assign bus.wr_en   = out_vld && !bus.full;
    assign bus.data_in = out_dat;
    assign bus.pkt_err = err_q;

    assign at_max = (len_q + LEN_W'(1)) == LEN_W'(MAX_PKT_LEN);
    assign trl_w  = DATA_WIDTH'(trl_word(32'(seq_q), 32'(len_q),
                                         DATA_WIDTH, SEQ_W));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        seq_d       = seq_q;
        err_d       = 1'b0;
        load        = 1'b0;
        ld_dat      = bus.s_data;
        bus.s_ready = 1'b0;
        unique case (state_q)
            S_DATA: begin
                bus.s_ready = can_load && !rst;
                if (bus.s_valid && bus.s_ready) begin
                    load  = 1'b1;
                    len_d = len_q + LEN_W'(1);
                    err_d = at_max && !bus.s_last;
                    if (bus.s_last || at_max) begin
                        state_d = S_TRL;
                    end
                end
            end
            // len_q holds the finished packet length here.
            S_TRL: begin
                if (can_load) begin
                    load    = 1'b1;
                    ld_dat  = trl_w;
                    seq_d   = seq_q + SEQ_W'(1);
                    len_d   = '0;
                    state_d = S_DATA;
                end
            end
        endcase
    end

    always_ff @(posedge clk_w or posedge rst) begin
        if (rst) begin
            state_q <= S_DATA;
            len_q   <= '0;
            seq_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            seq_q   <= seq_d;
            err_q   <= err_d;
        end
    end

    fifo_wr_stage #(
        .W(DATA_WIDTH)
    ) u_stage (
        .clk_w  (clk_w),
        .rst    (rst),
        .load_i (load),
        .pop_i  (bus.wr_en),
        .din_i  (ld_dat),
        .vld_o  (out_vld),
        .dat_o  (out_dat)
    );

`ifdef FIFO_WR_STATS_EN
    logic        trl_q;
    logic [15:0] cnt_q;

    always_ff @(posedge clk_w or posedge rst) begin
        if (rst) begin
            trl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (load) begin
                trl_q <= (state_q == S_TRL);
            end
            if (bus.wr_en && trl_q) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign pkt_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Bench for fifo_pkt_writer: queue-based model of the FIFO write stream.
module tb_fifo_pkt_writer;
    localparam int DW   = 8;
    localparam int SW   = 2;
    localparam int MAXL = 63;

    logic clk_w = 1'b0;
    logic rst   = 1'b1;

    fifo_pkt_writer_if #(.DATA_WIDTH(DW)) bus ();
`ifdef FIFO_WR_STATS_EN
    logic [15:0] pkt_cnt;
`endif

    fifo_pkt_writer #(
        .DATA_WIDTH  (DW),
        .SEQ_W       (SW),
        .MAX_PKT_LEN (MAXL)
    ) dut (
        .clk_w (clk_w),
        .rst   (rst),
        .bus   (bus)
`ifdef FIFO_WR_STATS_EN
        ,
        .pkt_cnt (pkt_cnt)
`endif
    );

    always #5 clk_w = ~clk_w;

    typedef struct {
        logic [DW-1:0] d;
        bit            trl;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] wlog[$];
    int            m_len, m_seq, m_cnt;
    bit            err_exp;
    logic          exp_rdy;
    int            total, bad, err_seen;
    bit            rand_full, force_full;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected FIFO stream: every accepted word, plus a trailer per packet.
    always @(negedge clk_w) begin
        ent_t e;
        if (rst) begin
            q.delete();
            m_len   = 0;
            m_seq   = 0;
            m_cnt   = 0;
            err_exp = 1'b0;
            chk("rst_wr_en", 32'(bus.wr_en), 0);
            chk("rst_s_ready", 32'(bus.s_ready), 0);
            chk("rst_data_in", 32'(bus.data_in), 0);
            chk("rst_pkt_err", 32'(bus.pkt_err), 0);
        end else begin
            chk("pkt_err", 32'(bus.pkt_err), 32'(err_exp));
            if (bus.pkt_err) err_seen++;
            exp_rdy = (q.size() < 2) && (q.size() == 0 || !bus.full);
            chk("s_ready", 32'(bus.s_ready), 32'(exp_rdy));
            chk("wr_en", 32'(bus.wr_en), 32'(q.size() > 0 && !bus.full));
            if (q.size() > 0) chk("data_in", 32'(bus.data_in), 32'(q[0].d));
`ifdef FIFO_WR_STATS_EN
            chk("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt[15:0]));
`endif
            if (bus.wr_en) begin
                wlog.push_back(bus.data_in);
                if (q.size() > 0) begin
                    if (q[0].trl) m_cnt++;
                    void'(q.pop_front());
                end
            end
            err_exp = 1'b0;
            if (bus.s_valid && bus.s_ready) begin
                e.d = bus.s_data;
                e.trl = 1'b0;
                q.push_back(e);
                m_len++;
                if (bus.s_last || m_len == MAXL) begin
                    err_exp = !bus.s_last;
                    e.d = DW'((m_seq << (DW - SW)) | m_len);
                    e.trl = 1'b1;
                    q.push_back(e);
                    m_seq = (m_seq + 1) % (1 << SW);
                    m_len = 0;
                end
            end
        end
    end

    initial begin
        bus.full = 1'b0;
        forever begin
            @(posedge clk_w);
            #2;
            bus.full = rand_full ? ($urandom_range(0, 3) == 0) : force_full;
        end
    end

    task automatic tick();
        @(posedge clk_w);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit last);
        int   n;
        logic rdy;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        forever begin
            @(negedge clk_w);
            rdy = bus.s_ready;
            tick();
            if (rdy) break;
            n++;
            if (n > 300) begin
                chk("send_timeout", 32'(n), 0);
                break;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        chk("drain", q.size(), 0);
        repeat (2) tick();
    endtask

    task automatic do_reset(input int cyc);
        rst = 1'b1;
        repeat (cyc) tick();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int wb, eb, len;
        total = 0;
        bad = 0;
        err_seen = 0;
        rand_full = 0;
        force_full = 0;
        bus.s_valid = 0;
        bus.s_data = '0;
        bus.s_last = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // three-word packet
        wb = wlog.size();
        send(8'hA1, 0);
        send(8'hA2, 0);
        send(8'hA3, 1);
        drain();
        chk("t1_cnt", wlog.size() - wb, 4);
        chk("t1_w0", 32'(wlog[wb]), 32'hA1);
        chk("t1_w2", 32'(wlog[wb+2]), 32'hA3);
        chk("t1_trl", 32'(wlog[wb+3]), 32'h03);

        // single-word packets and seq wrap
        wb = wlog.size();
        send(8'h55, 1);
        send(8'h66, 1);
        send(8'h77, 1);
        send(8'h88, 1);
        drain();
        chk("t2_w0", 32'(wlog[wb]), 32'h55);
        chk("t2_trl1", 32'(wlog[wb+1]), 32'h41);
        chk("t2_trl3", 32'(wlog[wb+5]), 32'hC1);
        chk("t2_trl4", 32'(wlog[wb+7]), 32'h01);

        // forced split at MAX_PKT_LEN
        do_reset(2);
        wb = wlog.size();
        eb = err_seen;
        for (int i = 0; i < 70; i++) send(DW'(8'h80 + i), i == 69);
        drain();
        chk("t3_cnt", wlog.size() - wb, 72);
        chk("t3_w62", 32'(wlog[wb+62]), 32'hBE);
        chk("t3_trl1", 32'(wlog[wb+63]), 32'h3F);
        chk("t3_w63", 32'(wlog[wb+64]), 32'hBF);
        chk("t3_trl2", 32'(wlog[wb+71]), 32'h47);
        chk("t3_err", err_seen - eb, 1);

        // full held for 10 cycles mid-packet
        wb = wlog.size();
        fork
            for (int i = 0; i < 8; i++) send(DW'(8'hD0 + i), i == 7);
            begin
                repeat (3) tick();
                force_full = 1;
                repeat (10) tick();
                force_full = 0;
            end
        join
        drain();
        chk("t4_cnt", wlog.size() - wb, 9);
        chk("t4_w3", 32'(wlog[wb+3]), 32'hD3);
        chk("t4_trl", 32'(wlog[wb+8]), 32'h88);

        // reset mid-packet
        send(8'h01, 0);
        send(8'h02, 0);
        do_reset(2);
        wb = wlog.size();
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 1);
        drain();
        chk("t5_cnt", wlog.size() - wb, 4);
        chk("t5_w0", 32'(wlog[wb]), 32'h11);
        chk("t5_trl", 32'(wlog[wb+3]), 32'h03);
`ifdef FIFO_WR_STATS_EN
        chk("t5_pkt_cnt", 32'(pkt_cnt), 1);
`endif

        // random packets with random back-pressure and gaps
        rand_full = 1;
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(1, 80);
            for (int i = 0; i < len; i++) begin
                send(DW'($urandom), i == len - 1);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
            end
        end
        rand_full = 0;
        repeat (2) tick();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
